ddr2_bank_ctrl: RTL
===================

Name: ddr2_bank_ctrl

Overview:
- Per-bank DDR2 command generator, one instance per bank, directly upstream of the command scheduler.
- Accepts decoded read/write requests for its bank and tracks the bank's open-row state.
- Enforces bank-level timing (tRCD, tRP, tRAS, tRTP, write-to-precharge, tRFC) and presents at most one ACT/RD/WR/PRE/REF request per cycle to the scheduler.
- Completes a command only on the matching scheduler grant.

Parameters:
- ROW_W, 14, row address width
- COL_W, 10, column address width
- T_RCD, 3, ACT to RD/WR, cycles (≥1)
- T_RP, 3, PRE to ACT/REF, cycles (≥1)
- T_RAS, 8, ACT to PRE, cycles (≥1)
- T_RTP, 2, RD to PRE, cycles (≥1)
- T_WTP, 7, WR to PRE (WL + BL/2 + tWR), cycles (≥1)
- T_RFC, 26, REF to next ACT, cycles (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request pending for this bank
- req_wr  in  1  1 = write, 0 = read
- req_row  in  ROW_W  request row
- req_col  in  COL_W  request column
- req_ready  out  1  request consumed this cycle
- ref_trig  in  1  one-cycle refresh demand from refresh timer
- ref_ack  out  1  one-cycle pulse, REF granted
- act_req / rd_req / wr_req / pre_req / ref_req  out  1 each  command requests to scheduler
- act_gnt / rd_gnt / wr_gnt / pre_gnt / ref_gnt  in  1 each  scheduler grants
- cmd_row  out  ROW_W  row for ACT (equals req_row)
- cmd_col  out  COL_W  column for RD/WR (equals req_col)
- bank_open  out  1  row open (state OPEN or ACTIVATING)
- open_row  out  ROW_W  currently open row

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; all counters and ref_pend cleared; open_row=0.
  - All *_req, req_ready and ref_ack are 0 the following cycle.
  - Reset mid-operation abandons any state, with no completion pulses.
- States: IDLE (closed), ACTIVATING, OPEN, PRECHARGING, REFRESHING.
- Timing counters:
  - A command granted at cycle t allows the dependent command no earlier than cycle t+N.
  - Implementation: load N-1 on the grant edge, decrement to 0 saturating, gate the request on counter==0.
  - Separate counters: state-wait counter (tRCD/tRP/tRFC), tRAS counter, precharge-hold counter (max of pending tRTP/tWTP; load the larger of current remainder and new value).
- ref_pend:
  - Set on ref_trig; cleared on ref_gnt.
  - ref_trig while already pending is absorbed (no counting).
  - ref_trig and ref_gnt in the same cycle leave ref_pend set.
- Requests (combinational, mutually exclusive):
  - IDLE: ref_pend → ref_req. Else req_valid → act_req, cmd_row=req_row.
  - ACTIVATING: no requests; state-wait counter==0 → OPEN.
  - OPEN: ref_pend, or req_valid with req_row≠open_row → pre_req once tRAS counter==0 and precharge-hold==0. Else req_valid and row hit → rd_req (req_wr=0) or wr_req (req_wr=1), cmd_col=req_col.
  - PRECHARGING, REFRESHING: no requests; state-wait counter==0 → IDLE.
- Refresh priority: refresh outranks new traffic; a pending refresh closes an open row even on a row hit.
- Grant handling:
  - A grant is honoured only when the matching request is asserted the same cycle; otherwise it is ignored.
  - act_gnt → open_row=req_row, load T_RCD and T_RAS, go to ACTIVATING.
  - rd_gnt/wr_gnt → req_ready=1 that same cycle (combinational from grant); load T_RTP/T_WTP into precharge-hold; stay OPEN.
  - pre_gnt → load T_RP, go to PRECHARGING.
  - ref_gnt → ref_ack=1 that same cycle; load T_RFC, go to REFRESHING.
- req_ready is asserted only with rd_gnt/wr_gnt; ACT and PRE never consume the request.
- Requests may change while req_valid=0; the block samples only while a request is asserted.

Test Plan:
- After reset: req_valid=1, rd, row 5, col 8. act_req appears at once; act_gnt at t0 → rd_req first at t0+3; rd_gnt → req_ready pulse; bank_open=1, open_row=5.
- Row hit stream with row 5 open: four back-to-back rd_gnt → four req_ready pulses, no pre_req/act_req.
- Row miss: row 5 open, write granted at t1, then a request to row 9. pre_req is held until max(ACT+8, t1+7); pre_gnt → act_req for row 9 exactly 3 cycles later.
- Refresh while open: ref_trig while a row-hit read is pending. Next request is pre_req, not rd_req; then ref_req after tRP; ref_gnt → ref_ack; act_req no earlier than 26 cycles after ref_gnt.
- Spurious grants: rd_gnt in IDLE and act_gnt in OPEN → no state change, req_ready=0.
- Reset mid-REFRESHING at cycle 10 of 26 → IDLE next cycle, all requests 0, ref_pend=0.

Source files
------------

// File: rtl/ddr2_bank_ctrl.sv
// Per-bank DDR2 command generator: tracks the open row of one bank, enforces
// bank-level timing and raises at most one ACT/RD/WR/PRE/REF request per cycle.
//
// Handshake: every *_req is a level held until its matching *_gnt arrives in
// the same cycle. A grant without its request is ignored. req_valid is a
// level the requester holds until req_ready pulses. req_ready is driven
// combinationally from rd_gnt/wr_gnt and consumes the request in that cycle.
// ref_trig is a one-cycle demand. ref_ack pulses in the cycle REF is granted.
module ddr2_bank_ctrl #(
    parameter int ROW_W = 14,
    parameter int COL_W = 10,
    parameter int T_RCD = 3,
    parameter int T_RP  = 3,
    parameter int T_RAS = 8,
    parameter int T_RTP = 2,
    parameter int T_WTP = 7,
    parameter int T_RFC = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_wr,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    output logic             req_ready,
    input  logic             ref_trig,
    output logic             ref_ack,
    output logic             act_req,
    output logic             rd_req,
    output logic             wr_req,
    output logic             pre_req,
    output logic             ref_req,
    input  logic             act_gnt,
    input  logic             rd_gnt,
    input  logic             wr_gnt,
    input  logic             pre_gnt,
    input  logic             ref_gnt,
    output logic [ROW_W-1:0] cmd_row,
    output logic [COL_W-1:0] cmd_col,
    output logic             bank_open,
    output logic [ROW_W-1:0] open_row,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ACTIVATING  = 3'd1,
        ST_OPEN        = 3'd2,
        ST_PRECHARGING = 3'd3,
        ST_REFRESHING  = 3'd4
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_RCD, T_RP), max2(T_RAS, T_RTP)),
                                max2(T_WTP, T_RFC));
    localparam int CW = $clog2(T_MAX + 1);
    typedef logic [CW-1:0] cnt_t;

    // A command granted at cycle t permits its dependent command at t+N:
    // counters load N-1 on the grant edge and reach zero at t+N.
    localparam cnt_t LD_RCD = cnt_t'(T_RCD - 1);
    localparam cnt_t LD_RP  = cnt_t'(T_RP - 1);
    localparam cnt_t LD_RAS = cnt_t'(T_RAS - 1);
    localparam cnt_t LD_RTP = cnt_t'(T_RTP - 1);
    localparam cnt_t LD_WTP = cnt_t'(T_WTP - 1);
    localparam cnt_t LD_RFC = cnt_t'(T_RFC - 1);

    state_t           state_q, state_d;
    cnt_t             wait_q, wait_d;
    cnt_t             ras_q, ras_d;
    cnt_t             hold_q, hold_d;
    cnt_t             hold_dec, hold_new;
    logic             ref_pend_q, ref_pend_d;
    logic [ROW_W-1:0] open_row_q, open_row_d;
    logic             row_hit;

    assign row_hit   = (req_row == open_row_q);
    assign cmd_row   = req_row;
    assign cmd_col   = req_col;
    assign open_row  = open_row_q;
    assign bank_open = (state_q == ST_OPEN) || (state_q == ST_ACTIVATING);
    assign state_dbg = state_q;

    // Next-state, counter updates and request/grant decoding.
    always_comb begin
        state_d    = state_q;
        wait_d     = (wait_q != '0) ? wait_q - cnt_t'(1) : '0;
        ras_d      = (ras_q  != '0) ? ras_q  - cnt_t'(1) : '0;
        hold_dec   = (hold_q != '0) ? hold_q - cnt_t'(1) : '0;
        hold_new   = '0;
        hold_d     = hold_dec;
        ref_pend_d = ref_pend_q | ref_trig;
        open_row_d = open_row_q;
        act_req    = 1'b0;
        rd_req     = 1'b0;
        wr_req     = 1'b0;
        pre_req    = 1'b0;
        ref_req    = 1'b0;
        req_ready  = 1'b0;
        ref_ack    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Refresh outranks new traffic.
                if (ref_pend_q) begin
                    ref_req = 1'b1;
                end else if (req_valid) begin
                    act_req = 1'b1;
                end
                if (ref_req && ref_gnt) begin
                    ref_ack    = 1'b1;
                    ref_pend_d = ref_trig;   // a fresh trigger survives the grant
                    wait_d     = LD_RFC;
                    state_d    = (T_RFC == 1) ? ST_IDLE : ST_REFRESHING;
                end else if (act_req && act_gnt) begin
                    open_row_d = req_row;
                    wait_d     = LD_RCD;
                    ras_d      = LD_RAS;
                    state_d    = (T_RCD == 1) ? ST_OPEN : ST_ACTIVATING;
                end
            end
            ST_ACTIVATING: begin
                // Leave one cycle early so OPEN coincides with the counter hitting zero.
                if (wait_q <= cnt_t'(1)) state_d = ST_OPEN;
            end
            ST_OPEN: begin
                // A pending refresh closes the row even on a row hit.
                if (ref_pend_q || (req_valid && !row_hit)) begin
                    pre_req = (ras_q == '0) && (hold_q == '0);
                end else if (req_valid) begin
                    rd_req = !req_wr;
                    wr_req = req_wr;
                end
                if (pre_req && pre_gnt) begin
                    wait_d  = LD_RP;
                    state_d = (T_RP == 1) ? ST_IDLE : ST_PRECHARGING;
                end else if ((rd_req && rd_gnt) || (wr_req && wr_gnt)) begin
                    req_ready = 1'b1;
                    hold_new  = rd_req ? LD_RTP : LD_WTP;
                    hold_d    = (hold_new > hold_dec) ? hold_new : hold_dec;
                end
            end
            ST_PRECHARGING, ST_REFRESHING: begin
                if (wait_q <= cnt_t'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            ras_q      <= '0;
            hold_q     <= '0;
            ref_pend_q <= 1'b0;
            open_row_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            ras_q      <= ras_d;
            hold_q     <= hold_d;
            ref_pend_q <= ref_pend_d;
            open_row_q <= open_row_d;
        end
    end

endmodule
